// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file read arbiter: scan FSM states,
// register count and a constant ceil(log2) used to size pointers and counters.
package regfile_arb_pkg;

    localparam int REG_COUNT = 32'sd32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    function automatic int CeilLog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester / read-mux / scan bundle of the register-file read arbiter.
// master = requesters plus the mux data source, slave = the arbiter itself.
interface regfile_read_arbiter_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NBITS       = 5,
    parameter int NREQ        = 3
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ*NBITS-1:0]       req_addr;
    logic [NREQ-1:0]             grant;
    logic [NBITS-1:0]            mux_selector;
    logic [WORD_LENGTH-1:0]      mux_data;
    logic [NREQ-1:0]             resp_valid;
    logic [NREQ*WORD_LENGTH-1:0] resp_data;
    logic                        scan_start;
    logic                        scan_busy;
    logic                        scan_valid;
    logic [NBITS-1:0]            scan_index;
    logic [WORD_LENGTH-1:0]      scan_data;
    logic                        scan_done;

    modport master (
        output req_valid, req_addr, mux_data, scan_start,
        input  grant, mux_selector, resp_valid, resp_data,
        input  scan_busy, scan_valid, scan_index, scan_data, scan_done
    );

    modport slave (
        input  req_valid, req_addr, mux_data, scan_start,
        output grant, mux_selector, resp_valid, resp_data,
        output scan_busy, scan_valid, scan_index, scan_data, scan_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick over a request vector: search upward from rr_ptr with wrap,
// and move rr_ptr past the winner when the caller lets the grant take effect.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PTR_W = (NREQ > 32'sd1) ? CeilLog2(NREQ) : 32'sd1;

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] win_idx_s;
    logic [PTR_W:0]   cand_s;
    logic             found_s;

    // Rotating priority search starting at rr_ptr_r
    always_comb begin
        grant     = '0;
        win_idx_s = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int i = 32'sd0; i < NREQ; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            if (cand_s >= (PTR_W+1)'(NREQ)) begin
                cand_s = cand_s - (PTR_W+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[PTR_W-1:0]]) begin
                found_s                    = 1'b1;
                grant[cand_s[PTR_W-1:0]]   = 1'b1;
                win_idx_s                  = cand_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves one past the winner only when the grant is honoured
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (advance && found_s) begin
            rr_ptr_r <= (win_idx_s == PTR_W'(NREQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the 32:1 register-file read mux among NREQ requesters and a background
// scan sequencer; zero-address bypass is enabled by REGFILE_ARB_ZERO_BYPASS_EN.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WORD_LENGTH  = 32,
    parameter int NBITS        = 5,
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_read_arbiter_if.slave   bus
);

    localparam int               STARVE_W = CeilLog2(STARVE_LIMIT + 32'sd1);
    localparam logic [NBITS-1:0] LAST_IDX = NBITS'(REG_COUNT - 32'sd1);

    scan_state_e                 state_r;
    scan_state_e                 state_nxt_s;
    logic [NBITS-1:0]            scan_cnt_r;
    logic [STARVE_W-1:0]         starve_r;

    logic [NREQ-1:0]             byp_s;
    logic [NREQ-1:0]             arb_req_s;
    logic [NREQ-1:0]             arb_grant_s;
    logic [NREQ-1:0]             mux_grant_s;
    logic [NREQ-1:0]             grant_s;
    logic                        in_scan_s;
    logic                        forced_s;
    logic                        scan_slot_s;
    logic [NBITS-1:0]            mux_sel_s;

    logic [NREQ-1:0]             resp_valid_r;
    logic [NREQ*WORD_LENGTH-1:0] resp_data_r;
    logic                        scan_valid_r;
    logic [NBITS-1:0]            scan_index_r;
    logic [WORD_LENGTH-1:0]      scan_data_r;
    logic                        scan_done_r;

`ifdef REGFILE_ARB_ZERO_BYPASS_EN
    // Address-0 reads are answered with a constant and never occupy the mux
    always_comb begin
        byp_s = '0;
        for (int i = 32'sd0; i < NREQ; i++) begin
            byp_s[i] = bus.req_valid[i] && (bus.req_addr[i*NBITS +: NBITS] == '0);
        end
    end
`else
    // Address 0 goes through the mux like any other register
    always_comb begin
        byp_s = '0;
    end
`endif

    assign arb_req_s   = bus.req_valid & ~byp_s;
    assign in_scan_s   = (state_r == S_SCAN);
    assign forced_s    = in_scan_s && (starve_r == STARVE_W'(STARVE_LIMIT));
    assign scan_slot_s = in_scan_s && ((arb_req_s == '0) || forced_s);

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req_s),
        .advance (!forced_s),
        .grant   (arb_grant_s)
    );

    // A forced scan slot stalls every requester, bypass included
    assign mux_grant_s = forced_s ? '0 : arb_grant_s;
    assign grant_s     = forced_s ? '0 : (arb_grant_s | byp_s);

    // Mux selector: scan slot, else the mux winner's address, else register 0
    always_comb begin
        mux_sel_s = '0;
        if (scan_slot_s) begin
            mux_sel_s = scan_cnt_r;
        end else begin
            for (int i = 32'sd0; i < NREQ; i++) begin
                if (mux_grant_s[i]) begin
                    mux_sel_s = bus.req_addr[i*NBITS +: NBITS];
                end else begin
                    mux_sel_s = mux_sel_s;
                end
            end
        end
    end

    // Scan FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.scan_start) begin
                    state_nxt_s = S_SCAN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (scan_slot_s && (scan_cnt_r == LAST_IDX)) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_SCAN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scan address walk and starvation counter; both rest at 0 outside S_SCAN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_r <= '0;
            starve_r   <= '0;
        end else if (in_scan_s) begin
            if (scan_slot_s) begin
                scan_cnt_r <= (scan_cnt_r == LAST_IDX) ? '0 : scan_cnt_r + NBITS'(1);
                starve_r   <= '0;
            end else if (starve_r != STARVE_W'(STARVE_LIMIT)) begin
                scan_cnt_r <= scan_cnt_r;
                starve_r   <= starve_r + STARVE_W'(1);
            end else begin
                scan_cnt_r <= scan_cnt_r;
                starve_r   <= starve_r;
            end
        end else begin
            scan_cnt_r <= '0;
            starve_r   <= '0;
        end
    end

    // Requester responses, one cycle after the grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_r <= '0;
            resp_data_r  <= '0;
        end else begin
            resp_valid_r <= grant_s;
            for (int i = 32'sd0; i < NREQ; i++) begin
                if (grant_s[i]) begin
                    resp_data_r[i*WORD_LENGTH +: WORD_LENGTH] <= byp_s[i] ? '0 : bus.mux_data;
                end else begin
                    resp_data_r[i*WORD_LENGTH +: WORD_LENGTH] <= resp_data_r[i*WORD_LENGTH +: WORD_LENGTH];
                end
            end
        end
    end

    // Scan beats; scan_done follows the S_DONE cycle so it lands after the last beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_valid_r <= 1'b0;
            scan_index_r <= '0;
            scan_data_r  <= '0;
            scan_done_r  <= 1'b0;
        end else begin
            scan_valid_r <= scan_slot_s;
            scan_done_r  <= (state_r == S_DONE);
            if (scan_slot_s) begin
                scan_index_r <= scan_cnt_r;
                scan_data_r  <= bus.mux_data;
            end else begin
                scan_index_r <= scan_index_r;
                scan_data_r  <= scan_data_r;
            end
        end
    end

    assign bus.grant        = reset ? '0 : grant_s;
    assign bus.mux_selector = reset ? '0 : mux_sel_s;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_data    = resp_data_r;
    assign bus.scan_busy    = in_scan_s;
    assign bus.scan_valid   = scan_valid_r;
    assign bus.scan_index   = scan_index_r;
    assign bus.scan_data    = scan_data_r;
    assign bus.scan_done    = scan_done_r;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: a register-file model feeds the mux,
// expected responses and scan beats go through scoreboard queues.
module tb_regfile_read_arbiter;

    localparam int WL = 32;
    localparam int NB = 5;
    localparam int NR = 3;

    typedef struct { int idx; logic [WL-1:0] data; } resp_t;
    typedef struct { logic [NB-1:0] idx; logic [WL-1:0] data; } scan_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [WL-1:0] regs [0:31];
    resp_t resp_q [$];
    scan_t scan_q [$];
    resp_t mon_resp;
    scan_t mon_scan;
    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int dones  = 0;
    logic [2:0] rr_seq [0:3] = '{3'b001, 3'b010, 3'b100, 3'b001};

    regfile_read_arbiter_if #(.WORD_LENGTH(WL), .NBITS(NB), .NREQ(NR)) bus ();
    assign bus.mux_data = regs[bus.mux_selector];

    regfile_read_arbiter #(.WORD_LENGTH(WL), .NBITS(NB), .NREQ(NR), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan();
        for (int i = 0; i < 32; i++) scan_q.push_back('{NB'(i), regs[i]});
    endtask

    task automatic push_resp(input int idx, input logic [WL-1:0] data);
        resp_q.push_back('{idx, data});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(bus.grant), 64'd0);
        chk({tag, "_mux_sel"}, 64'(bus.mux_selector), 64'd0);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_resp_data_nz"}, 64'(bus.resp_data != '0), 64'd0);
        chk({tag, "_scan_busy"}, 64'(bus.scan_busy), 64'd0);
        chk({tag, "_scan_valid"}, 64'(bus.scan_valid), 64'd0);
        chk({tag, "_scan_index"}, 64'(bus.scan_index), 64'd0);
        chk({tag, "_scan_data"}, 64'(bus.scan_data), 64'd0);
        chk({tag, "_scan_done"}, 64'(bus.scan_done), 64'd0);
    endtask

    // Bounded wait for a new scan_done pulse; n returns cycles waited
    task automatic wait_done(input int d0, input int limit, output int n);
        n = 0;
        while (dones == d0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_timeout", 64'(dones != d0), 64'd1);
    endtask

    // Output monitor: pops the scoreboards whenever the DUT produces a response or beat
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.resp_valid[i]) begin
                    if (resp_q.size() == 0) begin
                        chk("resp_unexpected", 64'(i) + 64'd1, 64'd0);
                    end else begin
                        mon_resp = resp_q.pop_front();
                        chk("resp_idx", 64'(i), 64'(mon_resp.idx));
                        chk("resp_data", 64'(bus.resp_data[i*WL +: WL]), 64'(mon_resp.data));
                    end
                end
            end
            if (bus.scan_valid) begin
                beats++;
                if (scan_q.size() == 0) begin
                    chk("scan_unexpected", 64'(bus.scan_index) + 64'd1, 64'd0);
                end else begin
                    mon_scan = scan_q.pop_front();
                    chk("scan_index", 64'(bus.scan_index), 64'(mon_scan.idx));
                    chk("scan_data", 64'(bus.scan_data), 64'(mon_scan.data));
                end
            end
            if (bus.scan_done) dones++;
        end
    end

    initial begin
        int n;
        int b0;
        int d0;
        for (int i = 0; i < 32; i++) regs[i] = {8'hA5, 8'(i), 8'(~i), 8'(i * 3 + 1)};
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.scan_start = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Round-robin with all three requesting registers 5/6/7
        bus.req_addr  = {5'd7, 5'd6, 5'd5};
        bus.req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 64'(bus.grant), 64'(rr_seq[k]));
            chk("rr_mux_sel", 64'(bus.mux_selector), 64'(5 + (k % 3)));
            push_resp(k % 3, regs[5 + (k % 3)]);
            @(negedge clk); #1;
            chk("rr_resp_latency", 64'(bus.resp_valid), 64'(rr_seq[k]));
        end
        bus.req_valid = '0;
        #1;
        chk("idle_grant", 64'(bus.grant), 64'd0);
        chk("idle_mux_sel", 64'(bus.mux_selector), 64'd0);
        @(negedge clk); @(negedge clk);

        // Full scan with no requests
        bus.scan_start = 1'b1;
        #1;
        chk("scan_start_grant", 64'(bus.grant), 64'd0);
        push_scan();
        @(negedge clk);
        bus.scan_start = 1'b0;
        #1;
        chk("scan_busy_on", 64'(bus.scan_busy), 64'd1);
        chk("scan_first_sel", 64'(bus.mux_selector), 64'd0);
        b0 = beats; d0 = dones;
        wait_done(d0, 100, n);
        chk("scan_done_cycle", 64'(n), 64'd33);
        chk("scan_beats", 64'(beats - b0), 64'd32);
        chk("scan_busy_off", 64'(bus.scan_busy), 64'd0);
        @(negedge clk); #1;
        chk("scan_done_pulse", 64'(bus.scan_done), 64'd0);
        chk("scan_done_count", 64'(dones - d0), 64'd1);

        // Scan starved by requester 0, with scan_start coinciding with the request
        @(negedge clk);
        bus.req_addr   = {5'd0, 5'd0, 5'd3};
        bus.req_valid  = 3'b001;
        bus.scan_start = 1'b1;
        push_scan();
        b0 = beats; d0 = dones;
        #1;
        chk("starve_start_grant", 64'(bus.grant), 64'd1);
        push_resp(0, regs[3]);
        @(negedge clk);
        bus.scan_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 8; s++) begin
                #1;
                chk("starve_stall_grant", 64'(bus.grant), 64'd1);
                push_resp(0, regs[3]);
                @(negedge clk);
            end
            #1;
            chk("starve_forced_grant", 64'(bus.grant), 64'd0);
            chk("starve_forced_sel", 64'(bus.mux_selector), 64'(p));
            @(negedge clk);
        end
        bus.req_valid = '0;
        wait_done(d0, 100, n);
        chk("starve_beats", 64'(beats - b0), 64'd32);
        @(negedge clk); @(negedge clk);

        // Address 0 and address 9 requested together
        bus.req_addr  = {5'd0, 5'd9, 5'd0};
        bus.req_valid = 3'b011;
        #1;
`ifdef REGFILE_ARB_ZERO_BYPASS_EN
        chk("byp_grant", 64'(bus.grant), 64'd3);
        chk("byp_mux_sel", 64'(bus.mux_selector), 64'd9);
        push_resp(0, 32'd0);
        push_resp(1, regs[9]);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("byp_idle_grant", 64'(bus.grant), 64'd0);
`else
        chk("zero_first_grant", 64'(bus.grant), 64'd2);
        chk("zero_first_sel", 64'(bus.mux_selector), 64'd9);
        push_resp(1, regs[9]);
        @(negedge clk);
        bus.req_valid = 3'b001;
        #1;
        chk("zero_second_grant", 64'(bus.grant), 64'd1);
        chk("zero_second_sel", 64'(bus.mux_selector), 64'd0);
        push_resp(0, regs[0]);
        @(negedge clk);
        bus.req_valid = '0;
`endif
        @(negedge clk); @(negedge clk);

        // scan_start repeated while busy and while in S_DONE is ignored
        bus.scan_start = 1'b1;
        push_scan();
        b0 = beats; d0 = dones;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.scan_start = (c == 10) || (c == 33);
        end
        bus.scan_start = 1'b0;
        #1;
        chk("restart_beats", 64'(beats - b0), 64'd32);
        chk("restart_dones", 64'(dones - d0), 64'd1);
        chk("restart_busy", 64'(bus.scan_busy), 64'd0);

        // Reset in the middle of a scan
        @(negedge clk);
        bus.scan_start = 1'b1;
        push_scan();
        b0 = beats;
        @(negedge clk);
        bus.scan_start = 1'b0;
        n = 0;
        while ((beats - b0) < 10 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("midscan_reach_beat10", 64'(beats - b0), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        scan_q.delete();
        d0 = dones;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        chk("reset_no_done", 64'(dones - d0), 64'd0);
        chk("reset_busy", 64'(bus.scan_busy), 64'd0);
        bus.req_addr  = {5'd0, 5'd8, 5'd4};
        bus.req_valid = 3'b011;
        #1;
        chk("post_reset_grant", 64'(bus.grant), 64'd1);
        push_resp(0, regs[4]);
        @(negedge clk);
        bus.req_valid = 3'b010;
        #1;
        chk("post_reset_grant2", 64'(bus.grant), 64'd2);
        push_resp(1, regs[8]);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); @(negedge clk);
        #1;

        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        chk("scan_q_empty", 64'(scan_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
